// File: rtl/uart_loader_pkg.sv
// Shared constants and helpers for the serial bus loader: frame bytes,
// response codes and the receive-deserialiser state type.
package uart_loader_pkg;

  localparam logic [7:0] LDR_SYNC  = 8'hA5;
  localparam logic [7:0] LDR_CMD_W = 8'h57;
  localparam logic [7:0] LDR_CMD_R = 8'h52;
  localparam logic [7:0] LDR_ACK   = 8'h06;
  localparam logic [7:0] LDR_NAK   = 8'h15;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == LDR_CMD_W) || (b == LDR_CMD_R);
  endfunction

endpackage

// File: rtl/uart_loader_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each
// CLK_DIV+1 clocks long. done_o marks the last clock of the stop bit.
module uart_byte_tx #(
  parameter int CLK_DIV = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       tx,
  output logic       done_o
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic          busy_q, busy_d;
  logic [9:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          bit_end;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy_q  <= 1'b0;
      shift_q <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bit_end = busy_q && (cnt_q == CW'(CLK_DIV));
    done_o  = bit_end && (bit_q == 4'd9);
    // Line is forced high whenever idle, so a reset truncates a byte at once.
    tx      = busy_q ? shift_q[0] : 1'b1;
    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        shift_d = {1'b1, data_i, 1'b0};
        cnt_d   = '0;
        bit_d   = '0;
      end
    end else if (bit_end) begin
      cnt_d   = '0;
      shift_d = {1'b1, shift_q[9:1]};
      bit_d   = bit_q + 4'd1;
      if (bit_q == 4'd9) busy_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Serial-host bus initiator: decodes A5/cmd/addr/data frames from rx,
// issues one 32-bit bus write or read, and answers on tx.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_DIV = 87,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_w_enable_o,
  output logic        mem_r_enable_o,
  input  logic [31:0] mem_data_i,
  output logic        busy_o
);
  localparam int RW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_SYNC, S_CMD, S_ADDR, S_DATA, S_BUS, S_RD, S_RESP, S_NAK
  } state_e;

  // Receive path
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e     rx_st_q, rx_st_d;
  logic [RW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  // Command FSM
  state_e        state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   addr_sh_q, addr_sh_d;
  logic [31:0]   data_sh_q, data_sh_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          tx_active_q, tx_active_d;
  logic          tx_start, tx_done;
  logic [7:0]    tx_byte;
  logic          in_frame;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        // Mid-start re-check rejects glitches shorter than half a bit.
        if (rx_cnt_q == RW'(CLK_DIV / 2)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + RW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == RW'(CLK_DIV)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + RW'(1);
        end
      end
      default: begin
        if (rx_cnt_q == RW'(CLK_DIV)) begin
          rx_st_d    = RX_IDLE;
          rx_valid_d = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + RW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_SYNC;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rdata_q     <= '0;
      to_cnt_q    <= '0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rdata_q     <= rdata_d;
      to_cnt_q    <= to_cnt_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign in_frame   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign busy_o     = (state_q != S_SYNC);
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

  always_comb begin
    state_d        = state_q;
    is_write_d     = is_write_q;
    byte_cnt_d     = byte_cnt_q;
    addr_sh_d      = addr_sh_q;
    data_sh_d      = data_sh_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    rdata_d        = rdata_q;
    to_cnt_d       = '0;
    tx_active_d    = tx_active_q;
    tx_start       = 1'b0;
    tx_byte        = LDR_NAK;
    mem_w_enable_o = 1'b0;
    mem_r_enable_o = 1'b0;
    if (in_frame) to_cnt_d = rx_valid_q ? '0 : to_cnt_q + TW'(1);

    case (state_q)
      S_SYNC: begin
        byte_cnt_d = '0;
        if (rx_valid_q && rx_sh_q == LDR_SYNC) state_d = S_CMD;
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (rx_valid_q) begin
          if (state_q == S_CMD) begin
            byte_cnt_d = '0;
            is_write_d = (rx_sh_q == LDR_CMD_W);
            state_d    = is_cmd(rx_sh_q) ? S_ADDR : S_NAK;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (state_q == S_ADDR) addr_sh_d = {rx_sh_q, addr_sh_q[31:8]};
            else                   data_sh_d = {rx_sh_q, data_sh_q[31:8]};
            // Bus outputs only change when a complete frame commits.
            if (byte_cnt_q == 2'd3) begin
              if (state_q == S_ADDR && is_write_q) begin
                state_d = S_DATA;
              end else begin
                state_d    = S_BUS;
                mem_addr_d = addr_sh_d;
                if (is_write_q) mem_data_d = data_sh_d;
              end
            end
          end
        end else if (rx_ferr_q || to_cnt_q >= TW'(TIMEOUT - 1)) begin
          state_d = S_SYNC;
        end
      end
      S_BUS: begin
        mem_w_enable_o = is_write_q;
        mem_r_enable_o = !is_write_q;
        byte_cnt_d     = '0;
        state_d        = is_write_q ? S_RESP : S_RD;
      end
      S_RD: begin
        rdata_d = mem_data_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        tx_byte  = is_write_q ? LDR_ACK : rdata_q[{byte_cnt_q, 3'b000} +: 8];
        tx_start = !tx_active_q;
        if (tx_done) begin
          if (is_write_q || byte_cnt_q == 2'd3) begin
            state_d    = S_SYNC;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        tx_start = !tx_active_q;
        if (tx_done) state_d = S_SYNC;
      end
    endcase

    if (tx_start)     tx_active_d = 1'b1;
    else if (tx_done) tx_active_d = 1'b0;
  end

  uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (tx_byte),
    .start_i(tx_start),
    .tx     (tx),
    .done_o (tx_done)
  );

endmodule

// File: tb/tb_uart_loader.sv
// Frame-level bench for uart_loader: a frame model predicts bus cycles and
// response bytes; one per-cycle process checks strobes and decodes tx.
module tb_uart_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_w_enable_o, mem_r_enable_o, busy_o;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] slave_rdata = 32'h0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_w = 0, n_r = 0;
  logic [31:0] last_addr = 32'h0, last_data = 32'h0;

  always #5 clk = ~clk;

  uart_loader #(.CLK_DIV(3), .TIMEOUT(200)) dut (
    .clk           (clk),
    .rst_n         (rst),
    .rx            (rx),
    .tx            (tx),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_w_enable_o(mem_w_enable_o),
    .mem_r_enable_o(mem_r_enable_o),
    .mem_data_i    (mem_data_i),
    .busy_o        (busy_o)
  );

  // Slave: read data valid only on the cycle after the read strobe.
  always @(posedge clk) mem_data_i <= mem_r_enable_o ? slave_rdata : 32'hBAD0BAD0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_frame(input logic [7:0] f[$], input logic [31:0] rd);
    bus_t t;
    if (f.size() < 2 || f[0] != 8'hA5) return;
    if (f[1] != 8'h57 && f[1] != 8'h52) begin
      exp_tx.push_back(8'h15);
      return;
    end
    t.wr   = (f[1] == 8'h57);
    t.addr = {f[5], f[4], f[3], f[2]};
    t.data = t.wr ? {f[9], f[8], f[7], f[6]} : 32'h0;
    exp_bus.push_back(t);
    if (t.wr) exp_tx.push_back(8'h06);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
  endfunction

  // Per-cycle compare: bus strobes against the model, tx decoded at bit centres.
  int         tx_cyc = -1;
  logic       tx_prev = 1'b1;
  logic [7:0] tx_d = 8'h0;
  always @(negedge clk) begin
    if (rst) begin
      tx_cyc = -1;
    end else begin
      if (mem_w_enable_o || mem_r_enable_o) begin
        check("strobe_busy", busy_o, 1'b1);
        check("strobe_excl", mem_w_enable_o & mem_r_enable_o, 1'b0);
        if (mem_w_enable_o) n_w++; else n_r++;
        last_addr = mem_addr_o;
        last_data = mem_data_o;
        if (exp_bus.size() == 0) begin
          check("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          bus_t t;
          t = exp_bus.pop_front();
          check("strobe_kind", mem_w_enable_o, t.wr);
          check("bus_addr", mem_addr_o, t.addr);
          if (t.wr) check("bus_wdata", mem_data_o, t.data);
        end
      end
      if (!tx) check("tx_low_busy", busy_o, 1'b1);
      if (tx_cyc < 0) begin
        if (tx_prev && !tx) tx_cyc = 0;
      end else begin
        tx_cyc++;
      end
      if (tx_cyc >= 0 && tx_cyc % 4 == 2) begin
        if (tx_cyc == 2) check("tx_start_bit", tx, 1'b0);
        else if (tx_cyc < 38) tx_d[tx_cyc/4 - 1] = tx;
        else begin
          check("tx_stop_bit", tx, 1'b1);
          tx_log.push_back(tx_d);
          if (exp_tx.size() == 0) check("unexpected_tx", {24'h0, tx_d}, 32'hFFFFFFFF);
          else check("tx_byte", tx_d, exp_tx.pop_front());
          tx_cyc = -1;
        end
      end
    end
    tx_prev = tx;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || busy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_complete"}, n < 3000, 1'b1);
    repeat (20) @(negedge clk);
    check({nm, "_idle_tx"}, tx, 1'b1);
    check({nm, "_idle_busy"}, busy_o, 1'b0);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] frm[$];
    int base, n;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_w", mem_w_enable_o, 1'b0);
    check("rst_r", mem_r_enable_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_data", mem_data_o, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1. write
    frm = '{8'hA5, 8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_frame(frm, slave_rdata);
    send_frame(frm);
    wait_done("t1");
    check("t1_nw", n_w, 1);
    check("t1_addr", last_addr, 32'h00000010);
    check("t1_data", last_data, 32'hDEADBEEF);
    check("t1_ack", tx_log[tx_log.size()-1], 8'h06);

    // 2. read
    slave_rdata = 32'h12345678;
    frm = '{8'hA5, 8'h52, 8'h20, 8'h00, 8'h00, 8'h00};
    model_frame(frm, slave_rdata);
    send_frame(frm);
    wait_done("t2");
    n = tx_log.size();
    check("t2_nr", n_r, 1);
    check("t2_addr", last_addr, 32'h00000020);
    check("t2_resp", {tx_log[n-1], tx_log[n-2], tx_log[n-3], tx_log[n-4]}, 32'h12345678);
    check("t2_data_held", mem_data_o, 32'hDEADBEEF);

    // 3. bad command, then a normal write
    frm = '{8'hA5, 8'h33};
    model_frame(frm, slave_rdata);
    send_frame(frm);
    wait_done("t3nak");
    check("t3_nak", tx_log[tx_log.size()-1], 8'h15);
    check("t3_nostrobe", n_w + n_r, 2);
    frm = '{8'hA5, 8'h57, 8'h04, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44};
    model_frame(frm, slave_rdata);
    send_frame(frm);
    wait_done("t3w");
    check("t3_addr", last_addr, 32'h80000004);
    check("t3_data", last_data, 32'h44332211);

    // 4a. timeout inside a frame
    base = tx_log.size();
    frm = '{8'hA5, 8'h57, 8'h10, 8'h00};
    send_frame(frm);
    check("t4_busy_in_frame", busy_o, 1'b1);
    repeat (250) @(negedge clk);
    check("t4_timeout_busy", busy_o, 1'b0);
    check("t4_no_tx", tx_log.size(), base);
    check("t4_no_strobe", n_w + n_r, 3);

    // 4b. glitch between sync and cmd must not be taken as a byte
    frm = '{8'hA5, 8'h57, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    model_frame(frm, slave_rdata);
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 1; i < 10; i++) send_byte(frm[i], 1'b1);
    wait_done("t4");
    check("t4_addr", last_addr, 32'h00000008);
    check("t4_data", last_data, 32'h00000001);

    // 5. framing error on the second address byte
    base = tx_log.size();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h52, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (100) @(negedge clk);
    check("t5_busy", busy_o, 1'b0);
    check("t5_no_tx", tx_log.size(), base);
    check("t5_no_strobe", n_w + n_r, 4);

    // 6. reset during the third response byte
    slave_rdata = 32'hCAFEF00D;
    frm = '{8'hA5, 8'h52, 8'h44, 8'h00, 8'h00, 8'h00};
    model_frame(frm, slave_rdata);
    base = tx_log.size();
    send_frame(frm);
    n = 0;
    while (tx_log.size() < base + 2 && n < 3000) begin @(negedge clk); n++; end
    check("t6_two_bytes", tx_log.size() >= base + 2, 1'b1);
    n = 0;
    while (tx && n < 50) begin @(negedge clk); n++; end
    check("t6_third_start", tx, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_tx", tx, 1'b1);
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_w", mem_w_enable_o, 1'b0);
    check("t6_rst_r", mem_r_enable_o, 1'b0);
    check("t6_rst_addr", mem_addr_o, 32'h0);
    exp_tx.delete();
    exp_bus.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    slave_rdata = 32'h0BADC0DE;
    frm = '{8'hA5, 8'h52, 8'h48, 8'h00, 8'h00, 8'h00};
    model_frame(frm, slave_rdata);
    send_frame(frm);
    wait_done("t6");
    n = tx_log.size();
    check("t6_addr", last_addr, 32'h00000048);
    check("t6_resp", {tx_log[n-1], tx_log[n-2], tx_log[n-3], tx_log[n-4]}, 32'h0BADC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
